// File: rtl/pwl_sym_pipe.sv
// -----------------------------------------------------------------------------
// pwl_sym_pipe
//   Multi-lane, stall-able piecewise-linear evaluator:
//       y = k[idx] * frac / 2^V + b[idx]
//   The result is saturated to the signed W = M+N bit input format.
//   Optional symmetry folding (odd/even) lets a half table serve symmetric
//   activations. The coefficient table is written at run time and shared by
//   all lanes, with one read port per lane.
//
//   Pipeline: S0 fold/index -> S1 table read -> S2 k*frac -> S3 add/align/sat/mirror
//   Four clocks from acceptance to out_valid. All stages advance together on en.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   input handshake (in_ready drops while cfg_we is high)
//   x_in                LANES signed W-bit inputs, lane i at [i*W +: W]
//   sym_mode            0 none, 1 odd, 2 even, 3 treated as none; sampled per beat
//   out_valid/out_ready output handshake
//   y_out, sat_flag     per-lane saturated results and saturation flags
//   cfg_we/addr/data    table write port, data = {k, b}, both signed
//   sat_count           (only with PWL_SAT_CNT_EN) saturating count of set
//                       sat_flag bits over output transfers, cleared by reset
//
// Build option: define PWL_SAT_CNT_EN to add the sat_count output and counter.
// -----------------------------------------------------------------------------
module pwl_sym_pipe #(
    parameter int M         = 4,
    parameter int N         = 8,
    parameter int U         = 8,
    parameter int V         = 4,
    parameter int LANES     = 2,
    parameter int K_WIDTH_I = 4,
    parameter int K_WIDTH_F = 12,
    parameter int B_WIDTH_I = 4,
    parameter int B_WIDTH_F = 12
) (
    input  logic                                               clk,
    input  logic                                               rst_n,
    input  logic                                               in_valid,
    output logic                                               in_ready,
    input  logic [LANES*(M+N)-1:0]                             x_in,
    input  logic [1:0]                                         sym_mode,
    output logic                                               out_valid,
    input  logic                                               out_ready,
    output logic [LANES*(M+N)-1:0]                             y_out,
    output logic [LANES-1:0]                                   sat_flag,
    input  logic                                               cfg_we,
    input  logic [U-1:0]                                       cfg_addr,
    input  logic [K_WIDTH_I+K_WIDTH_F+B_WIDTH_I+B_WIDTH_F-1:0] cfg_data
`ifdef PWL_SAT_CNT_EN
    ,
    output logic [15:0]                                        sat_count
`endif
);

    localparam int W    = M + N;
    localparam int KW   = K_WIDTH_I + K_WIDTH_F;
    localparam int BW   = B_WIDTH_I + B_WIDTH_F;
    localparam int CW   = KW + BW;
    localparam int PW   = KW + V + 1;                  // k * {0,frac}
    localparam int SW   = ((PW > BW) ? PW : BW) + 1;   // (p>>>V) + b, cannot overflow
    localparam int SH_R = (B_WIDTH_F > N) ? (B_WIDTH_F - N) : 0;
    localparam int SH_L = (N > B_WIDTH_F) ? (N - B_WIDTH_F) : 0;
    localparam int AW   = SW + SH_L;                   // room for a left align

    localparam logic signed [AW-1:0] A_MAX  = AW'((2 ** (W - 1)) - 1);
    localparam logic signed [AW-1:0] A_MIN  = ~A_MAX;
    localparam logic        [W-1:0]  YW_MAX = {1'b0, {(W - 1){1'b1}}};
    localparam logic        [W-1:0]  YW_MIN = {1'b1, {(W - 1){1'b0}}};

    // ---------------- handshake and stage valids ----------------
    logic en, accept, fold, odd;
    logic s0_valid_d, s0_valid_q, s1_valid_d, s1_valid_q;
    logic s2_valid_d, s2_valid_q, s3_valid_d, s3_valid_q;

    always_comb begin
        en         = !s3_valid_q || out_ready;
        in_ready   = en && !cfg_we;
        accept     = in_valid && in_ready;
        fold       = (sym_mode == 2'd1) || (sym_mode == 2'd2);
        odd        = (sym_mode == 2'd1);
        // Bubbles advance like beats, so no collapsing and order is kept.
        s0_valid_d = en ? accept     : s0_valid_q;
        s1_valid_d = en ? s0_valid_q : s1_valid_q;
        s2_valid_d = en ? s1_valid_q : s2_valid_q;
        s3_valid_d = en ? s2_valid_q : s3_valid_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_valid_q <= 1'b0;
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s3_valid_q <= 1'b0;
        end else begin
            s0_valid_q <= s0_valid_d;
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            s3_valid_q <= s3_valid_d;
        end
    end

    assign out_valid = s3_valid_q;

    // ---------------- coefficient table ----------------
    // Reads are non-blocking, so a read of an address being written in the
    // same cycle returns the old entry.
    logic [CW-1:0] table_mem [2**U];

    always_ff @(posedge clk) begin
        if (cfg_we) begin
            table_mem[cfg_addr] <= cfg_data;
        end
    end

    // ---------------- per-lane datapath ----------------
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic        [W-1:0]  x;
        logic        [W-2:0]  a;
        logic        [U-1:0]  idx_d, idx_q;
        logic        [V-1:0]  frac0_d, frac0_q, frac1_d, frac1_q;
        logic                 mir0_d, mir0_q, mir1_d, mir1_q, mir2_d, mir2_q;
        logic        [CW-1:0] coef_q;
        logic signed [KW-1:0] k1;
        logic signed [BW-1:0] b1, b2_d, b2_q;
        logic signed [PW-1:0] p_d, p_q;
        logic signed [SW-1:0] s;
        logic signed [AW-1:0] al;
        logic        [W-1:0]  y_sat, y_d, y_q;
        logic                 clip, sat_d, sat_q;

        // S0: magnitude fold and index/fraction split
        always_comb begin
            x = x_in[gi*W +: W];
            // |x| in W-1 bits; the most negative input clamps to the max magnitude
            if (!x[W-1]) begin
                a = x[W-2:0];
            end else if (x[W-2:0] == '0) begin
                a = '1;
            end else begin
                a = ~x[W-2:0] + 1'b1;
            end
            idx_d   = idx_q;
            frac0_d = frac0_q;
            mir0_d  = mir0_q;
            if (en) begin
                if (fold) begin
                    idx_d   = a[W-2 -: U];
                    frac0_d = a[V-1:0];
                end else begin
                    idx_d   = x[W-1 -: U];
                    frac0_d = x[V-1:0];
                end
                mir0_d = odd && x[W-1];
            end
        end

        // S1: registered table read, held while stalled
        always_ff @(posedge clk) begin
            if (en) begin
                coef_q <= table_mem[idx_q];
            end
        end

        // S2: k * frac (frac is unsigned, so zero-extend before the signed multiply)
        always_comb begin
            k1      = coef_q[CW-1 -: KW];
            b1      = coef_q[BW-1:0];
            frac1_d = en ? frac0_q : frac1_q;
            mir1_d  = en ? mir0_q  : mir1_q;
            p_d     = en ? (k1 * $signed({1'b0, frac1_q})) : p_q;
            b2_d    = en ? b1      : b2_q;
            mir2_d  = en ? mir1_q  : mir2_q;
        end

        // S3: add offset, align to N fraction bits, clamp, then mirror
        always_comb begin
            s  = SW'(p_q >>> V) + SW'(b2_q);
            al = AW'(s);
            al = al <<< SH_L;
            al = al >>> SH_R;
            clip = 1'b0;
            if (al > A_MAX) begin
                y_sat = YW_MAX;
                clip  = 1'b1;
            end else if (al < A_MIN) begin
                y_sat = YW_MIN;
                clip  = 1'b1;
            end else begin
                y_sat = al[W-1:0];
            end
            y_d   = y_sat;
            sat_d = clip;
            if (mir2_q) begin
                // Negating the most negative value cannot be represented.
                if (y_sat == YW_MIN) begin
                    y_d   = YW_MAX;
                    sat_d = 1'b1;
                end else begin
                    y_d = -y_sat;
                end
            end
            if (!en) begin
                y_d   = y_q;
                sat_d = sat_q;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                idx_q   <= '0;
                frac0_q <= '0;
                frac1_q <= '0;
                mir0_q  <= 1'b0;
                mir1_q  <= 1'b0;
                mir2_q  <= 1'b0;
                p_q     <= '0;
                b2_q    <= '0;
                y_q     <= '0;
                sat_q   <= 1'b0;
            end else begin
                idx_q   <= idx_d;
                frac0_q <= frac0_d;
                frac1_q <= frac1_d;
                mir0_q  <= mir0_d;
                mir1_q  <= mir1_d;
                mir2_q  <= mir2_d;
                p_q     <= p_d;
                b2_q    <= b2_d;
                y_q     <= y_d;
                sat_q   <= sat_d;
            end
        end

        assign y_out[gi*W +: W] = y_q;
        assign sat_flag[gi]     = sat_q;
    end

`ifdef PWL_SAT_CNT_EN
    // ---------------- saturation event counter ----------------
    logic [15:0] sat_cnt_d, sat_cnt_q;
    logic [16:0] sat_sum;

    always_comb begin
        sat_sum   = {1'b0, sat_cnt_q};
        sat_cnt_d = sat_cnt_q;
        if (s3_valid_q && out_ready) begin
            for (int i = 0; i < LANES; i++) begin
                sat_sum = sat_sum + 17'(sat_flag[i]);
            end
            sat_cnt_d = sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_cnt_q <= '0;
        end else begin
            sat_cnt_q <= sat_cnt_d;
        end
    end

    assign sat_count = sat_cnt_q;
`endif

endmodule

// File: tb/tb_pwl_sym_pipe.sv
// -----------------------------------------------------------------------------
// tb_pwl_sym_pipe
//   Directed bench for pwl_sym_pipe at M=4, N=8, U=8, V=4, two lanes,
//   Q4.12 coefficients. Inputs are driven on the falling edge and outputs
//   are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_pwl_sym_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] x_in;
    logic [1:0]  sym_mode;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] y_out;
    logic [1:0]  sat_flag;
    logic        cfg_we;
    logic [7:0]  cfg_addr;
    logic [31:0] cfg_data;

    int n_checks = 0;
    int n_errors = 0;

    pwl_sym_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_in      (x_in),
        .sym_mode  (sym_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y_out     (y_out),
        .sat_flag  (sat_flag),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
        $display("check %-20s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic write_cfg(input logic [7:0] addr, input logic [15:0] k, input logic [15:0] b);
        @(negedge clk);
        cfg_we   = 1'b1;
        cfg_addr = addr;
        cfg_data = {k, b};
        @(negedge clk);
        cfg_we   = 1'b0;
    endtask

    // Send one beat into an empty pipe and wait (bounded) for its result.
    // lat counts clock edges from the accepting edge to out_valid.
    task automatic run_beat(input logic [11:0] x0, input logic [11:0] x1, input logic [1:0] mode,
                            output logic [11:0] y0, output logic [11:0] y1,
                            output logic [1:0] sat, output int lat);
        @(negedge clk);
        x_in      = {x1, x0};
        sym_mode  = mode;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        y0  = y_out[11:0];
        y1  = y_out[23:12];
        sat = sat_flag;
    endtask

    logic [11:0] y0, y1, exp0, exp1;
    logic [1:0]  sat;
    logic [23:0] prev_y;
    logic [11:0] si;
    int          lat, sent, rcv, n;
    logic        prev_stall, fire_in, fire_out, seen;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        x_in      = '0;
        sym_mode  = 2'd0;
        out_ready = 1'b1;
        cfg_we    = 1'b0;
        cfg_addr  = '0;
        cfg_data  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_y_out", y_out, 0);
        check("rst_sat_flag", sat_flag, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);

        // ---- 1: latency and basic function ----
        write_cfg(8'h10, 16'h1000, 16'h0800);
        run_beat(12'h104, 12'h10C, 2'd0, y0, y1, sat, lat);
        check("t1_latency", lat, 4);
        check("t1_y_lane0", y0, 12'h0C0);
        check("t1_y_lane1", y1, 12'h140);
        check("t1_sat", sat, 2'b00);

        // ---- 2: odd / even folding, reserved mode ----
        write_cfg(8'h20, 16'h1000, 16'h0800);
        write_cfg(8'hEF, 16'h0000, 16'h0100);
        run_beat(12'hEFC, 12'h104, 2'd1, y0, y1, sat, lat);
        check("t2_odd_neg", y0, 12'hF40);
        check("t2_odd_pos", y1, 12'h0C0);
        run_beat(12'hEFC, 12'h104, 2'd2, y0, y1, sat, lat);
        check("t2_even_neg", y0, 12'h0C0);
        check("t2_even_pos", y1, 12'h0C0);
        run_beat(12'hEFC, 12'h104, 2'd3, y0, y1, sat, lat);
        check("t2_mode3_idxEF", y0, 12'h010);
        check("t2_mode3_idx10", y1, 12'h0C0);

        // ---- 3: saturation and mirror boundaries ----
        write_cfg(8'hFF, 16'h7FFF, 16'h7FFF);
        write_cfg(8'h7F, 16'h7FFF, 16'h7FFF);
        write_cfg(8'h01, 16'h0000, 16'h8000);
        run_beat(12'h7FF, 12'h104, 2'd0, y0, y1, sat, lat);
        check("t3_pos_sat_y", y0, 12'h7FF);
        check("t3_nosat_y", y1, 12'h0C0);
        check("t3_sat_flags", sat, 2'b01);
        // most negative input folds to idx 0xFF, saturates, then mirrors
        run_beat(12'h800, 12'h7FF, 2'd1, y0, y1, sat, lat);
        check("t3_min_odd_y", y0, 12'h801);
        check("t3_max_odd_y", y1, 12'h7FF);
        check("t3_odd_flags", sat, 2'b11);
        run_beat(12'h800, 12'h104, 2'd2, y0, y1, sat, lat);
        check("t3_min_even_y", y0, 12'h7FF);
        check("t3_even_flags", sat, 2'b01);
        // b = -8.0 gives exactly -2^11: not clamped, but mirroring it saturates
        run_beat(12'hFF8, 12'h008, 2'd1, y0, y1, sat, lat);
        check("t3_mirror_min_y", y0, 12'h7FF);
        check("t3_exact_min_y", y1, 12'h800);
        check("t3_mirror_flags", sat, 2'b01);

        // ---- 4: back-to-back beats with backpressure ----
        sent       = 0;
        rcv        = 0;
        prev_stall = 1'b0;
        prev_y     = '0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            si        = 12'(sent);
            out_ready = !(c >= 3 && c <= 6);
            in_valid  = (sent < 10);
            x_in      = {12'h10F - si, 12'h100 + si};
            sym_mode  = 2'd0;
            #1;
            if (prev_stall) begin
                check("t4_hold_valid", out_valid, 1);
                check("t4_hold_y", y_out, prev_y);
            end
            if (out_valid && !out_ready) begin
                check("t4_in_ready_full", in_ready, 0);
                prev_stall = 1'b1;
                prev_y     = y_out;
            end else begin
                prev_stall = 1'b0;
            end
            fire_in  = in_valid && in_ready;
            fire_out = out_valid && out_ready;
            if (fire_out) begin
                exp0 = 12'h080 + 12'h010 * 12'(rcv);
                exp1 = 12'h080 + 12'h010 * (12'd15 - 12'(rcv));
                check("t4_beat_y", y_out, {exp1, exp0});
                rcv++;
            end
            @(posedge clk);
            if (fire_in) sent++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("t4_sent", sent, 10);
        check("t4_received", rcv, 10);
        @(negedge clk);
        check("t4_no_extra", out_valid, 0);

        // ---- 5: table write colliding with the S1 read ----
        @(negedge clk);
        x_in      = {12'h10C, 12'h104};
        sym_mode  = 2'd0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        cfg_we   = 1'b1;
        cfg_addr = 8'h10;
        cfg_data = 32'h0000_0000;
        in_valid = 1'b1;
        #1 check("t5_in_ready_cfg", in_ready, 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        cfg_we   = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("t5_old_coef_y", y_out, {12'h140, 12'h0C0});
        run_beat(12'h104, 12'h10C, 2'd0, y0, y1, sat, lat);
        check("t5_new_coef_y0", y0, 12'h000);
        check("t5_new_coef_y1", y1, 12'h000);

        // ---- 6: reset with beats in flight ----
        write_cfg(8'h10, 16'h1000, 16'h0800);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            x_in      = {12'h10C, 12'h104};
            sym_mode  = 2'd0;
            in_valid  = 1'b1;
            out_ready = 1'b1;
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        check("t6_pre_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", out_valid, 0);
        check("t6_rst_y", y_out, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("t6_no_stale", seen, 0);
        check("t6_in_ready", in_ready, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
